dmio_lsu: RTL and testbench



---
 rtl/dmio_lsu.sv | 160 ++++++++++++++++
 tb/tb_dmio_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmio_lsu.sv
// dmio_lsu: load/store sequencer between the core memory stage and DMIO.
// Converts byte/half/word/dword requests on byte addresses into doubleword
// DMIO accesses. Sub-doubleword data-memory stores become read-modify-write,
// loads are sign/zero extended, and misaligned requests never touch the bus.
module dmio_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [12:0] mem_address,
    output logic [63:0] mem_data_write,
    output logic        mem_wr,
    input  logic [63:0] mem_data_read
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  r_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [2:0]  r_offset;
    logic [63:0] r_wdata;
    logic [12:0] r_mem_address;
    logic [63:0] r_mem_data_write;
    logic [63:0] r_resp_rdata;
    logic        r_resp_misaligned;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_direct_wr;
    logic [5:0]  w_shamt;
    logic [63:0] w_lane_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic [63:0] w_merged;

    assign req_ready       = (r_state == S_IDLE);
    assign resp_valid      = (r_state == S_RESP);
    // Decoded from state so that reset drops the write strobe asynchronously.
    assign mem_wr          = (r_state == S_WR);
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_resp_misaligned;
    assign mem_address     = r_mem_address;
    assign mem_data_write  = r_mem_data_write;

    assign w_accept    = req_valid && req_ready;
    // Full doublewords and every IO-region store skip the read phase.
    assign w_direct_wr = (req_size == 2'b11) || req_addr[15];
    assign w_shamt     = {r_offset, 3'b000};
    assign w_shifted   = mem_data_read >> w_shamt;
    assign w_merged    = (mem_data_read & ~(w_lane_mask << w_shamt))
                       | ((r_wdata & w_lane_mask) << w_shamt);

    // Alignment check on the incoming request.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    // Byte-lane mask for the captured access width.
    always_comb begin
        w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (r_size)
            2'b00:   w_lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Sign or zero extension of the lane-aligned load data.
    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            2'b00: w_load_data = {{56{w_shifted[7]  & ~r_unsigned}}, w_shifted[7:0]};
            2'b01: w_load_data = {{48{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            2'b10: w_load_data = {{32{w_shifted[31] & ~r_unsigned}}, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Sequencer: request capture, DMIO phases and response generation.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_size            <= 2'b00;
            r_unsigned        <= 1'b0;
            r_offset          <= 3'd0;
            r_wdata           <= 64'd0;
            r_mem_address     <= 13'd0;
            r_mem_data_write  <= 64'd0;
            r_resp_rdata      <= 64'd0;
            r_resp_misaligned <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size            <= req_size;
                        r_unsigned        <= req_unsigned;
                        r_offset          <= req_addr[2:0];
                        r_wdata           <= req_wdata;
                        r_resp_rdata      <= 64'd0;
                        r_resp_misaligned <= w_misaligned;
                        if (w_misaligned) begin
                            r_state <= S_RESP;
                        end else begin
                            r_mem_address <= req_addr[15:3];
                            if (!req_store) begin
                                r_state <= S_LOAD;
                            end else if (w_direct_wr) begin
                                r_mem_data_write <= req_wdata;
                                r_state          <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_state      <= S_RESP;
                end
                S_RD: begin
                    r_mem_data_write <= w_merged;
                    r_state          <= S_WR;
                end
                S_WR: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_resp_misaligned <= 1'b0;
                    r_state           <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmio_lsu.sv
// tb_dmio_lsu: directed bench for dmio_lsu with a behavioural DMIO model
// (data memory, LED register, switches) and a response scoreboard.
module tb_dmio_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic [12:0] mem_address;
    logic [63:0] mem_data_write;
    logic        mem_wr;
    logic [63:0] mem_data_read;

    logic [63:0] mem [0:4095];
    logic [7:0]  led;
    logic [7:0]  switches;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    dmio_lsu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_address     (mem_address),
        .mem_data_write  (mem_data_write),
        .mem_wr          (mem_wr),
        .mem_data_read   (mem_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMIO model: combinational read, write on the rising edge.
    assign mem_data_read = mem_address[12] ? {56'd0, switches} : mem[mem_address[11:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_address[12]) led <= mem_data_write[7:0];
            else                 mem[mem_address[11:0]] <= mem_data_write;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, then wait (bounded) for its response and score it.
    task automatic do_req(input string tag, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [15:0] addr, input logic [63:0] wd,
                          input logic [63:0] e_rdata, input logic e_mis, input int e_lat,
                          input int e_wrs, input logic [12:0] e_waddr, input logic [63:0] e_wdata);
        exp_t e;
        exp_t got_e;
        bit   got;
        int   nwr;
        logic [12:0] waddr;
        logic [63:0] wdata;
        exp_q.push_back('{rdata: e_rdata, mis: e_mis, lat: e_lat});
        @(negedge clk);
        check({tag, " idle resp_valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, " ready"}, {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = '1;
        got   = 1'b0;
        nwr   = 0;
        waddr = '0;
        wdata = '0;
        got_e = '{rdata: '0, mis: 1'b0, lat: 0};
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (mem_wr) begin
                nwr++;
                waddr = mem_address;
                wdata = mem_data_write;
            end
            if (resp_valid) begin
                got   = 1'b1;
                got_e = '{rdata: resp_rdata, mis: resp_misaligned, lat: i};
            end
        end
        check({tag, " response seen"}, {63'd0, got}, 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " rdata"}, got_e.rdata, e.rdata);
            check({tag, " misaligned"}, {63'd0, got_e.mis}, {63'd0, e.mis});
            check({tag, " latency"}, 64'(got_e.lat), 64'(e.lat));
        end
        check({tag, " mem_wr cycles"}, 64'(nwr), 64'(e_wrs));
        if (e_wrs > 0) begin
            check({tag, " write addr"}, {51'd0, waddr}, {51'd0, e_waddr});
            check({tag, " write data"}, wdata, e_wdata);
        end
    endtask

    initial begin
        bit saw_resp;
        bit saw_wr;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
        led          = 8'd0;
        switches     = 8'h3C;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 16'd0;
        req_wdata    = 64'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset req_ready", {63'd0, req_ready}, 64'd1);
        check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        check("reset resp_misaligned", {63'd0, resp_misaligned}, 64'd0);
        check("reset mem_address", {51'd0, mem_address}, 64'd0);
        check("reset mem_data_write", mem_data_write, 64'd0);
        check("reset mem_wr", {63'd0, mem_wr}, 64'd0);

        // Doubleword store and load back.
        do_req("sd 0x40", 1, 2'b11, 0, 16'h0040, 64'h0123456789ABCDEF,
               64'd0, 0, 2, 1, 13'h008, 64'h0123456789ABCDEF);
        do_req("ld 0x40", 0, 2'b11, 0, 16'h0040, 64'd0,
               64'h0123456789ABCDEF, 0, 2, 0, 13'h0, 64'd0);

        // Byte read-modify-write; upper wdata bits must be ignored.
        do_req("sb 0x42", 1, 2'b00, 0, 16'h0042, 64'h123456789ABCDEFF,
               64'd0, 0, 3, 1, 13'h008, 64'h0123456789FFCDEF);
        check("mem after sb", mem[8], 64'h0123456789FFCDEF);

        // Extension cases.
        do_req("lb 0x42", 0, 2'b00, 0, 16'h0042, 64'd0,
               64'hFFFFFFFFFFFFFFFF, 0, 2, 0, 13'h0, 64'd0);
        do_req("lbu 0x42", 0, 2'b00, 1, 16'h0042, 64'd0,
               64'h00000000000000FF, 0, 2, 0, 13'h0, 64'd0);
        do_req("lh 0x46", 0, 2'b01, 0, 16'h0046, 64'd0,
               64'h0000000000000123, 0, 2, 0, 13'h0, 64'd0);
        do_req("lw 0x40", 0, 2'b10, 0, 16'h0040, 64'd0,
               64'hFFFFFFFF89FFCDEF, 0, 2, 0, 13'h0, 64'd0);
        do_req("lwu 0x40", 0, 2'b10, 1, 16'h0040, 64'd0,
               64'h0000000089FFCDEF, 0, 2, 0, 13'h0, 64'd0);

        // Half read-modify-write at offset 4, then read it back signed.
        do_req("sh 0x44", 1, 2'b01, 0, 16'h0044, 64'h00000000AAAABEEF,
               64'd0, 0, 3, 1, 13'h008, 64'h0123BEEF89FFCDEF);
        do_req("lh 0x44", 0, 2'b01, 0, 16'h0044, 64'd0,
               64'hFFFFFFFFFFFFBEEF, 0, 2, 0, 13'h0, 64'd0);

        // Misaligned requests: no bus write, response after one cycle.
        do_req("lw 0x42 mis", 0, 2'b10, 0, 16'h0042, 64'd0,
               64'd0, 1, 1, 0, 13'h0, 64'd0);
        do_req("sh 0x41 mis", 1, 2'b01, 0, 16'h0041, 64'hFFFF,
               64'd0, 1, 1, 0, 13'h0, 64'd0);
        do_req("sd 0x44 mis", 1, 2'b11, 0, 16'h0044, 64'hFFFF,
               64'd0, 1, 1, 0, 13'h0, 64'd0);
        check("mem after mis", mem[8], 64'h0123BEEF89FFCDEF);

        // IO region: direct write without RD phase, switches readback.
        do_req("sb io", 1, 2'b00, 0, 16'h8000, 64'h00000000000000A5,
               64'd0, 0, 2, 1, 13'h1000, 64'h00000000000000A5);
        check("led", {56'd0, led}, 64'hA5);
        do_req("lbu io", 0, 2'b00, 1, 16'h8000, 64'd0,
               64'h000000000000003C, 0, 2, 0, 13'h0, 64'd0);

        // Reset asserted during the RD cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size  = 2'b00;
        req_addr  = 16'h0040;
        req_wdata = 64'h11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw rd mem_wr", {63'd0, mem_wr}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst async ready", {63'd0, req_ready}, 64'd1);
        check("rst async mem_wr", {63'd0, mem_wr}, 64'd0);
        saw_resp = 1'b0;
        saw_wr   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
            if (mem_wr)     saw_wr   = 1'b1;
        end
        check("rst no resp", {63'd0, saw_resp}, 64'd0);
        check("rst no write", {63'd0, saw_wr}, 64'd0);
        check("rst ready after", {63'd0, req_ready}, 64'd1);
        check("rst mem unchanged", mem[8], 64'h0123BEEF89FFCDEF);

        do_req("ld after rst", 0, 2'b11, 0, 16'h0040, 64'd0,
               64'h0123BEEF89FFCDEF, 0, 2, 0, 13'h0, 64'd0);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
